mealy_stream_sched: RTL and testbench

Round-robin scheduler that time-shares one Mealy sequence-detector datapath between `N_REQ` serial bit-stream requesters. It keeps a private detector-state context per requester, so interleaved streams are detected independently. It issues at most one bit per cycle to the shared detector and reports hits tagged with their source. It sits inside `tt_um_dev_mealy`, between the pin-level input streams and the detector core.

---
 rtl/mealy_sched_pkg.sv | 12 +
 rtl/mealy_stream_sched_rr_arbiter.sv | 31 +++
 rtl/mealy_stream_sched.sv | 109 ++++++++++
 tb/tb_mealy_stream_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mealy_sched_pkg.sv
// mealy_sched_pkg: shared defaults and types for the Mealy stream scheduler.
package mealy_sched_pkg;

    localparam int DEF_N_REQ   = 2;
    localparam int DEF_STATE_W = 3;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_BURST   = 4;
    localparam int RESET_STATE = 0;

    typedef logic [DEF_STATE_W-1:0] ctx_t;

endpackage

// File: rtl/mealy_stream_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible requester after last_grant.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    int j;

    // Scan from the requester just after last_grant; the first eligible one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(last_grant) + k) % N;
            if (!any && eligible[j]) begin
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mealy_stream_sched.sv
// mealy_stream_sched: round-robin time-sharing of one Mealy detector among N_REQ bit streams.
// Optional per-requester saturating hit counters: define MEALY_SCHED_HITCNT_EN.
module mealy_stream_sched
    import mealy_sched_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int STATE_W = DEF_STATE_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST   = DEF_BURST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_bit,
    input  logic [N_REQ-1:0]         req_flush,
    output logic [N_REQ-1:0]         req_ready,
    output logic [STATE_W-1:0]       det_state_o,
    output logic                     det_in_o,
    output logic                     det_fire_o,
    input  logic [STATE_W-1:0]       det_next_i,
    input  logic                     det_hit_i,
    output logic                     hit_valid,
    output logic [$clog2(N_REQ)-1:0] hit_src,
    output logic [N_REQ*CNT_W-1:0]   hit_cnt_o
);

    localparam int SW = $clog2(N_REQ);
    localparam int BW = $clog2(BURST + 1);

    logic [STATE_W-1:0] ctx [N_REQ];
    logic [SW-1:0]      last_grant;
    logic [SW-1:0]      arb_idx;
    logic [SW-1:0]      g;
    logic [BW-1:0]      burst_cnt;
    logic               lock;
    logic               lock_hit;
    logic               arb_any;
    logic               fire;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   arb_grant;

    // Reset and a pending flush both veto the grant, so flush always beats accept.
    assign eligible = {N_REQ{ena & ~rst}} & req_valid & ~req_flush;

    rr_arbiter #(.N(N_REQ), .IW(SW)) u_arb (
        .eligible  (eligible),
        .last_grant(last_grant),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // The lock holder keeps the detector while it offers bits and has burst budget left.
    always_comb begin
        lock_hit    = lock & eligible[last_grant] & (burst_cnt < BW'(BURST - 1));
        g           = lock_hit ? last_grant : arb_idx;
        fire        = lock_hit | arb_any;
        req_ready   = fire ? (N_REQ'(1) << g) : '0;
        det_fire_o  = fire;
        det_state_o = fire ? ctx[g] : '0;
        det_in_o    = fire & req_bit[g];
    end

    // Scheduler state: pointer, burst lock, contexts and the registered hit report.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SW'(N_REQ - 1);
            burst_cnt  <= '0;
            lock       <= 1'b0;
            hit_valid  <= 1'b0;
            hit_src    <= '0;
            for (int r = 0; r < N_REQ; r++) ctx[r] <= STATE_W'(RESET_STATE);
        end else if (ena) begin
            for (int r = 0; r < N_REQ; r++)
                if (req_flush[r]) ctx[r] <= STATE_W'(RESET_STATE);
            if (fire) begin
                ctx[g]     <= det_next_i;
                hit_src    <= g;
                last_grant <= g;
            end
            hit_valid <= fire & det_hit_i;
            lock      <= fire;
            burst_cnt <= lock_hit ? burst_cnt + 1'b1 : '0;
        end
    end

`ifdef MEALY_SCHED_HITCNT_EN
    logic [CNT_W-1:0] cnt [N_REQ];

    // Saturating counters fed by the registered hit strobe; flush clears its own counter.
    always_ff @(posedge clk) begin
        for (int r = 0; r < N_REQ; r++) begin
            if (rst) cnt[r] <= '0;
            else if (ena) begin
                if (req_flush[r]) cnt[r] <= '0;
                else if (hit_valid && hit_src == SW'(r) && cnt[r] != '1) cnt[r] <= cnt[r] + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        assign hit_cnt_o[i*CNT_W +: CNT_W] = cnt[i];
    end
`else
    assign hit_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mealy_stream_sched.sv
// tb_mealy_stream_sched: directed scenarios plus random traffic against a bit-history reference model.
module tb_mealy_stream_sched;

    localparam int N     = 2;
    localparam int SWID  = 3;
    localparam int CW    = 2;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    logic [N-1:0] req_valid = '0, req_bit = '0, req_flush = '0;
    logic [N-1:0] req_ready;
    logic [SWID-1:0] det_state_o, det_next_i;
    logic det_in_o, det_fire_o, det_hit_i, hit_valid;
    logic [0:0] hit_src;
    logic [N*CW-1:0] hit_cnt_o;

    int n_pass = 0, n_total = 0;

    mealy_stream_sched #(.N_REQ(N), .STATE_W(SWID), .CNT_W(CW), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .req_valid(req_valid), .req_bit(req_bit), .req_flush(req_flush), .req_ready(req_ready),
        .det_state_o(det_state_o), .det_in_o(det_in_o), .det_fire_o(det_fire_o),
        .det_next_i(det_next_i), .det_hit_i(det_hit_i),
        .hit_valid(hit_valid), .hit_src(hit_src), .hit_cnt_o(hit_cnt_o)
    );

    always #5 clk = ~clk;

    // Overlapping "101" detector: 0 = nothing, 1 = seen "1", 2 = seen "10".
    always_comb begin
        det_next_i = 3'd0;
        det_hit_i  = 1'b0;
        if (det_in_o) begin
            det_next_i = 3'd1;
            det_hit_i  = (det_state_o == 3'd2);
        end else det_next_i = (det_state_o == 3'd1) ? 3'd2 : 3'd0;
    end

`ifdef MEALY_SCHED_HITCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    // Reference model: last three accepted bits per stream, grant history, counters.
    logic [2:0] h [N];
    int  m_last = N - 1, m_run = 0, m_hs = 0;
    bit  m_lock = 0, m_hv = 0;
    int  m_cnt [N];

    logic [N-1:0] exp_ready, obs_ready;
    logic [SWID-1:0] exp_state, obs_state;
    logic exp_fire, exp_in, obs_fire, obs_in, obs_hv;
    logic [0:0] obs_hs;
    logic [N*CW-1:0] obs_cnt;

    function automatic int sfx(logic [2:0] x);
        return x[0] ? 1 : (x[1:0] == 2'b10 ? 2 : 0);
    endfunction

    function automatic logic [N*CW-1:0] m_cnt_vec();
        return {CW'(m_cnt[1]), CW'(m_cnt[0])};
    endfunction

    // One clock: predict the grant, sample outputs mid-cycle, then advance the model at the edge.
    task automatic cyc();
        int g;
        bit lk;
        bit e [N];
        g  = -1;
        lk = 0;
        for (int r = 0; r < N; r++) e[r] = !rst && ena && req_valid[r] && !req_flush[r];
        if (m_lock && e[m_last] && m_run < BURST) begin
            g  = m_last;
            lk = 1;
        end else
            for (int k = 1; k <= N; k++)
                if (g < 0 && e[(m_last + k) % N]) g = (m_last + k) % N;
        exp_fire  = (g >= 0);
        exp_ready = (g >= 0) ? N'(1 << g) : '0;
        exp_state = (g >= 0) ? SWID'(sfx(h[g])) : '0;
        exp_in    = (g >= 0) ? req_bit[g] : 1'b0;
        @(negedge clk);
        obs_ready = req_ready;
        obs_fire  = det_fire_o;
        obs_state = det_state_o;
        obs_in    = det_in_o;
        obs_hv    = hit_valid;
        obs_hs    = hit_src;
        obs_cnt   = hit_cnt_o;
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                h[r]     = 3'b000;
                m_cnt[r] = 0;
            end
            m_last = N - 1; m_run = 0; m_lock = 0; m_hv = 0; m_hs = 0;
        end else if (ena) begin
            for (int r = 0; r < N; r++) begin
                if (req_flush[r]) begin
                    h[r]     = 3'b000;
                    m_cnt[r] = 0;
                end else if (CNT_ON && m_hv && m_hs == r && m_cnt[r] < (1 << CW) - 1) m_cnt[r]++;
            end
            if (g >= 0) begin
                h[g]   = {h[g][1:0], exp_in};
                m_hv   = (h[g] == 3'b101);
                m_hs   = g;
                m_run  = lk ? m_run + 1 : 1;
                m_lock = 1;
                m_last = g;
            end else begin
                m_hv = 0; m_lock = 0; m_run = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; ena = 1; req_valid = 2'b11; req_bit = 2'b11;
        repeat (2) begin
            cyc();
            n_total++;
            if ({obs_ready, obs_fire, obs_state, obs_in, obs_hv, obs_hs, obs_cnt} !== '0)
                $display("FAIL reset_outputs got %b want 0", {obs_ready, obs_fire, obs_state, obs_in, obs_hv, obs_hs, obs_cnt});
            else n_pass++;
            n_total++;
            if ({hit_valid, hit_src, hit_cnt_o} !== '0) $display("FAIL reset_regs got %b want 0", {hit_valid, hit_src, hit_cnt_o});
            else n_pass++;
        end
        rst = 0;
        cyc();
        n_total++;
        if (obs_ready !== 2'b01) $display("FAIL reset_first_ready got %b want 01", obs_ready);
        else n_pass++;
    endtask

    task automatic test_single_stream();
        int s [5] = '{1, 0, 1, 0, 1};
        req_valid = 2'b00; req_flush = 2'b11;
        cyc();
        req_flush = 2'b00; req_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            req_bit = {1'b0, 1'(s[i])};
            cyc();
            n_total++;
            if (obs_ready !== 2'b01) $display("FAIL single_ready[%0d] got %b want 01", i, obs_ready);
            else n_pass++;
            n_total++;
            if (hit_valid !== (i == 2 || i == 4)) $display("FAIL single_hit[%0d] got %b want %b", i, hit_valid, (i == 2 || i == 4));
            else n_pass++;
            if (i == 4) begin
                n_total++;
                if (hit_src !== 1'b0) $display("FAIL single_src got %0d want 0", hit_src);
                else n_pass++;
            end
        end
        req_valid = 2'b00;
        cyc();
        n_total++;
        if (hit_cnt_o[CW-1:0] !== CW'(CNT_ON ? 2 : 0)) $display("FAIL single_cnt0 got %0d want %0d", hit_cnt_o[CW-1:0], CNT_ON ? 2 : 0);
        else n_pass++;
    endtask

    task automatic test_interleave();
        int gs [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        int b0 [5] = '{0, 0, 1, 0, 1};
        int b1 [4] = '{1, 0, 0, 0};
        int c0 = 0, c1 = 0;
        rst = 1; req_valid = 2'b00;
        cyc();
        rst = 0; req_valid = 2'b11;
        for (int i = 0; i < 9; i++) begin
            req_bit = {1'(c1 < 4 ? b1[c1] : 0), 1'(c0 < 5 ? b0[c0] : 0)};
            cyc();
            n_total++;
            if (obs_ready !== N'(1 << gs[i])) $display("FAIL interleave_grant[%0d] got %b want %b", i, obs_ready, N'(1 << gs[i]));
            else n_pass++;
            n_total++;
            if (hit_valid !== (i == 8)) $display("FAIL interleave_hit[%0d] got %b want %b", i, hit_valid, (i == 8));
            else n_pass++;
            if (gs[i] == 0) c0++; else c1++;
        end
        n_total++;
        if (hit_src !== 1'b0) $display("FAIL interleave_src got %0d want 0", hit_src);
        else n_pass++;
    endtask

    task automatic test_flush_collision();
        int s [3] = '{1, 0, 1};
        rst = 1; req_valid = 2'b00;
        cyc();
        rst = 0; req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            req_bit = {1'b0, 1'(s[i])};
            cyc();
        end
        n_total++;
        if (obs_state !== 3'd2) $display("FAIL flush_pre_state got %0d want 2", obs_state);
        else n_pass++;
        req_valid = 2'b11; req_flush = 2'b01; req_bit = 2'b00;
        cyc();
        n_total++;
        if (obs_ready !== 2'b10) $display("FAIL flush_ready got %b want 10", obs_ready);
        else n_pass++;
        n_total++;
        if (hit_cnt_o[CW-1:0] !== '0) $display("FAIL flush_cnt0 got %0d want 0", hit_cnt_o[CW-1:0]);
        else n_pass++;
        req_flush = 2'b00; req_valid = 2'b01; req_bit = 2'b01;
        cyc();
        n_total++;
        if ({obs_ready, obs_state} !== {2'b01, 3'd0}) $display("FAIL flush_ctx0 got ready %b state %0d want 01/0", obs_ready, obs_state);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int hits = 0;
        rst = 1; req_valid = 2'b00;
        cyc();
        rst = 0; req_valid = 2'b10;
        for (int i = 0; i < 11; i++) begin
            req_bit = {1'(i % 2 == 0), 1'b0};
            cyc();
            if (hit_valid && hit_src == 1'b1) hits++;
        end
        req_valid = 2'b00;
        repeat (2) cyc();
        n_total++;
        if (hits !== 5) $display("FAIL sat_hits got %0d want 5", hits);
        else n_pass++;
        n_total++;
        if (hit_cnt_o[2*CW-1:CW] !== CW'(CNT_ON ? 3 : 0)) $display("FAIL sat_cnt1 got %0d want %0d", hit_cnt_o[2*CW-1:CW], CNT_ON ? 3 : 0);
        else n_pass++;
    endtask

    task automatic test_enable_pause();
        rst = 1; req_valid = 2'b00;
        cyc();
        rst = 0; ena = 1; req_valid = 2'b11; req_bit = 2'b00;
        repeat (3) begin
            cyc();
            n_total++;
            if (obs_ready !== 2'b01) $display("FAIL pause_pre got %b want 01", obs_ready);
            else n_pass++;
        end
        ena = 0;
        repeat (3) begin
            cyc();
            n_total++;
            if (obs_ready !== 2'b00) $display("FAIL pause_idle got %b want 00", obs_ready);
            else n_pass++;
        end
        ena = 1;
        cyc();
        n_total++;
        if (obs_ready !== 2'b01) $display("FAIL pause_last got %b want 01", obs_ready);
        else n_pass++;
        cyc();
        n_total++;
        if (obs_ready !== 2'b10) $display("FAIL pause_rotate got %b want 10", obs_ready);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            ena       = ($urandom_range(0, 9) != 0);
            req_valid = N'($urandom_range(0, 3));
            req_bit   = N'($urandom_range(0, 3));
            req_flush = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            cyc();
            n_total++;
            if ({obs_ready, obs_fire, obs_state, obs_in} !== {exp_ready, exp_fire, exp_state, exp_in})
                $display("FAIL rand_det[%0d] got %b/%b/%0d/%b want %b/%b/%0d/%b", i,
                         obs_ready, obs_fire, obs_state, obs_in, exp_ready, exp_fire, exp_state, exp_in);
            else n_pass++;
            n_total++;
            if ({hit_valid, hit_src} !== {m_hv, 1'(m_hs)}) $display("FAIL rand_hit[%0d] got %b/%0d want %b/%0d", i, hit_valid, hit_src, m_hv, m_hs);
            else n_pass++;
            n_total++;
            if (hit_cnt_o !== m_cnt_vec()) $display("FAIL rand_cnt[%0d] got %h want %h", i, hit_cnt_o, m_cnt_vec());
            else n_pass++;
        end
    endtask

    initial begin
        for (int r = 0; r < N; r++) begin
            h[r]     = 3'b000;
            m_cnt[r] = 0;
        end
        test_reset();
        test_single_stream();
        test_interleave();
        test_flush_collision();
        test_saturation();
        test_enable_pause();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
